// File: rtl/nrisc_pkg.sv
// Shared NRISC definitions: datapath width, special register numbers and the
// write-back FIFO entry layout.
package nrisc_pkg;

  localparam int TAM = 16;

  localparam logic [3:0] REG_ZERO      = 4'd0;
  localparam logic [3:0] REG_R1        = 4'd1;
  localparam logic [3:0] REG_BANK_BASE = 4'd8;

  typedef struct packed {
    logic           valid;
    logic           bank;
    logic [3:0]     rd;
    logic [TAM-1:0] data;
  } wb_entry_t;

  // r0 is hardwired zero and r1 lives outside the regfile
  function automatic logic rd_writable(input logic [3:0] rd);
    return (rd != REG_ZERO) && (rd != REG_R1);
  endfunction

  function automatic logic [15:0] rd_onehot(input logic [3:0] rd);
    logic [15:0] m;
    m     = '0;
    m[rd] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/nrisc_wb_fifo.sv
// In-order LSU result buffer: per-entry valid, destination kill on younger ALU
// writes, and the OR of pending destinations.
module nrisc_wb_fifo
  import nrisc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_push,
  input  logic           i_push_kill,
  input  logic           i_push_bank,
  input  logic [3:0]     i_push_rd,
  input  logic [TAM-1:0] i_push_data,
  input  logic           i_pop,
  input  logic           i_kill,
  input  logic [3:0]     i_kill_rd,
  output wb_entry_t      o_head,
  output logic           o_nonempty,
  output logic           o_full,
  output logic           o_any_valid,
  output logic [15:0]    o_pend_mask
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  wb_entry_t      r_mem [DEPTH];
  logic [AW-1:0]  r_wptr, r_rptr;
  logic [AW:0]    r_count;
  logic           w_push, w_pop;

  assign o_nonempty = (r_count != '0);
  assign o_full     = (r_count == CNT_FULL);
  assign o_head     = r_mem[r_rptr];
  assign w_push     = i_push && !o_full;
  assign w_pop      = i_pop && o_nonempty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (i_kill && r_mem[i].rd == i_kill_rd) r_mem[i].valid <= 1'b0;
      if (w_pop) begin
        r_mem[r_rptr].valid <= 1'b0;
        r_rptr              <= r_rptr + AW'(1);
      end
      // push slot never equals the popped slot: push needs !full, pop needs !empty
      if (w_push) begin
        r_mem[r_wptr] <= '{valid: !i_push_kill, bank: i_push_bank,
                           rd: i_push_rd, data: i_push_data};
        r_wptr        <= r_wptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    o_pend_mask = '0;
    o_any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_mem[i].valid) begin
        o_pend_mask = o_pend_mask | rd_onehot(r_mem[i].rd);
        o_any_valid = 1'b1;
      end
    end
    o_pend_mask[1:0] = 2'b00;
  end

endmodule

// File: rtl/nrisc_wb_unit.sv
// Write-back unit: ALU results take the regfile port first, buffered LSU results
// drain in order behind them. TAM must match nrisc_pkg::TAM.
module nrisc_wb_unit #(
  parameter int TAM   = 16,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           alu_valid,
  input  logic [3:0]     alu_rd,
  input  logic [TAM-1:0] alu_data,
  input  logic           lsu_valid,
  output logic           lsu_ready,
  input  logic [3:0]     lsu_rd,
  input  logic [TAM-1:0] lsu_data,
  input  logic           irq_flag,
  output logic [TAM-1:0] REG_D,
  output logic [3:0]     REG_RFD,
  output logic           REG_Write,
  output logic [15:0]    pend_mask,
  output logic           wb_empty
);
  import nrisc_pkg::*;

  wb_entry_t      w_head;
  logic           w_nonempty, w_full, w_any_valid;
  logic [15:0]    w_fifo_mask;
  logic           w_alu_ok, w_push, w_push_kill, w_head_stall, w_drain, w_pop;
  logic           r_write;
  logic [3:0]     r_rfd;
  logic [TAM-1:0] r_d;

  assign w_alu_ok     = alu_valid && rd_writable(alu_rd);
  assign w_push       = lsu_valid && lsu_ready && rd_writable(lsu_rd);
  // ALU result is program-order younger, so a same-cycle LSU push to rd is dead
  assign w_push_kill  = w_alu_ok && (alu_rd == lsu_rd);
  assign w_head_stall = (w_head.rd >= REG_BANK_BASE) && (w_head.bank != irq_flag);
  assign w_drain      = w_nonempty && w_head.valid && !w_head_stall && !w_alu_ok;
  // killed heads retire without using the port, even while the ALU owns it
  assign w_pop        = w_nonempty && (!w_head.valid || w_drain);

  nrisc_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_kill (w_push_kill),
    .i_push_bank (irq_flag),
    .i_push_rd   (lsu_rd),
    .i_push_data (lsu_data),
    .i_pop       (w_pop),
    .i_kill      (w_alu_ok),
    .i_kill_rd   (alu_rd),
    .o_head      (w_head),
    .o_nonempty  (w_nonempty),
    .o_full      (w_full),
    .o_any_valid (w_any_valid),
    .o_pend_mask (w_fifo_mask)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write <= 1'b0;
      r_rfd   <= '0;
      r_d     <= '0;
    end else begin
      r_write <= w_alu_ok || w_drain;
      if (w_alu_ok) begin
        r_rfd <= alu_rd;
        r_d   <= alu_data;
      end else if (w_drain) begin
        r_rfd <= w_head.rd;
        r_d   <= w_head.data;
      end
    end
  end

  assign REG_Write = r_write;
  assign REG_RFD   = r_rfd;
  assign REG_D     = r_d;
  assign lsu_ready = !w_full;
  assign pend_mask = w_fifo_mask | (r_write ? rd_onehot(r_rfd) : 16'h0000);
  assign wb_empty  = !w_any_valid && !r_write;

endmodule

// File: tb/tb_nrisc_wb_unit.sv
// Scenario bench for nrisc_wb_unit: expected regfile writes are queued as
// stimulus is driven and compared whenever the write strobe is seen.
module tb_nrisc_wb_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid, lsu_ready, irq_flag;
  logic [3:0]  alu_rd, lsu_rd, REG_RFD;
  logic [15:0] alu_data, lsu_data, REG_D, pend_mask;
  logic        REG_Write, wb_empty;

  typedef struct packed { logic [3:0] rd; logic [15:0] d; } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;

  nrisc_wb_unit #(.TAM(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .irq_flag(irq_flag),
    .REG_D(REG_D), .REG_RFD(REG_RFD), .REG_Write(REG_Write),
    .pend_mask(pend_mask), .wb_empty(wb_empty)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic expw(input logic [3:0] rd, input logic [15:0] d);
    q.push_back('{rd: rd, d: d});
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
  endtask

  // advance one clock and score any write that lands on the port
  task automatic step();
    exp_t e;
    @(posedge clk); #1;
    if (REG_Write === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: write rd=%0d data=%h, none expected", REG_RFD, REG_D);
      end else begin
        e = q.pop_front();
        if (REG_RFD !== e.rd || REG_D !== e.d) begin
          errors++;
          $display("FAIL wb_write: got rd=%0d data=%h, expected rd=%0d data=%h",
                   REG_RFD, REG_D, e.rd, e.d);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1; idle(); irq_flag = 0;
    #12;
    checks++;
    if (REG_Write !== 0 || REG_D !== 0 || REG_RFD !== 0 || pend_mask !== 0 ||
        wb_empty !== 1 || lsu_ready !== 1) begin
      errors++;
      $display("FAIL reset_init: wr=%b d=%h rfd=%0d pend=%h empty=%b rdy=%b",
               REG_Write, REG_D, REG_RFD, pend_mask, wb_empty, lsu_ready);
    end
    @(negedge clk); rst = 0;
    // build up queued LSU work behind a busy ALU, then reset mid-cycle
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1; alu_rd = 2; alu_data = 16'h0100 + 16'(i); expw(2, alu_data);
      lsu_valid = 1; lsu_rd = 4'(3 + i); lsu_data = 16'h0F00 + 16'(i);
      step();
    end
    #2; rst = 1; #1;
    checks++;
    if (REG_Write !== 0 || REG_D !== 0 || REG_RFD !== 0 || pend_mask !== 0 ||
        wb_empty !== 1 || lsu_ready !== 1) begin
      errors++;
      $display("FAIL reset_mid: wr=%b d=%h rfd=%0d pend=%h empty=%b rdy=%b",
               REG_Write, REG_D, REG_RFD, pend_mask, wb_empty, lsu_ready);
    end
    q.delete();
    idle();
    @(negedge clk); rst = 0;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (wb_empty !== 1 || pend_mask !== 0) begin
      errors++;
      $display("FAIL reset_discard: empty=%b pend=%h, expected 1/0000", wb_empty, pend_mask);
    end
  endtask

  task automatic test_alu_write();
    alu_valid = 1; alu_rd = 5; alu_data = 16'h1234; expw(5, 16'h1234);
    step();
    idle();
    checks++;
    if (REG_Write !== 1 || pend_mask !== 16'h0020) begin
      errors++;
      $display("FAIL alu_n1: wr=%b pend=%h, expected 1/0020", REG_Write, pend_mask);
    end
    step();
    checks++;
    if (REG_Write !== 0 || pend_mask !== 16'h0000 || wb_empty !== 1) begin
      errors++;
      $display("FAIL alu_n2: wr=%b pend=%h empty=%b, expected 0/0000/1", REG_Write, pend_mask, wb_empty);
    end
  endtask

  task automatic test_full_drain();
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1; alu_rd = 2; alu_data = 16'h0200 + 16'(i); expw(2, alu_data);
      lsu_valid = 1; lsu_rd = 4'(3 + i); lsu_data = 16'h00A0 + 16'(i);
      checks++;
      if (lsu_ready !== 1) begin
        errors++;
        $display("FAIL full_ready_%0d: lsu_ready=%b, expected 1", i, lsu_ready);
      end
      step();
    end
    idle();
    checks++;
    if (lsu_ready !== 0 || pend_mask !== 16'h007C) begin
      errors++;
      $display("FAIL full_state: rdy=%b pend=%h, expected 0/007c", lsu_ready, pend_mask);
    end
    for (int i = 0; i < 4; i++) expw(4'(3 + i), 16'h00A0 + 16'(i));
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (REG_Write !== 1 || REG_RFD !== 4'(3 + i)) begin
        errors++;
        $display("FAIL drain_%0d: wr=%b rfd=%0d, expected 1/%0d", i, REG_Write, REG_RFD, 3 + i);
      end
    end
    step();
    checks++;
    if (REG_Write !== 0 || wb_empty !== 1 || lsu_ready !== 1) begin
      errors++;
      $display("FAIL drain_end: wr=%b empty=%b rdy=%b, expected 0/1/1", REG_Write, wb_empty, lsu_ready);
    end
  endtask

  task automatic test_kill();
    alu_valid = 1; alu_rd = 2; alu_data = 16'h0222; expw(2, 16'h0222);
    lsu_valid = 1; lsu_rd = 9; lsu_data = 16'hAAAA;
    step();
    alu_rd = 9; alu_data = 16'h5555; expw(9, 16'h5555);
    lsu_valid = 0;
    step();
    idle();
    checks++;
    if (pend_mask !== 16'h0200 || wb_empty !== 0) begin
      errors++;
      $display("FAIL kill_pend: pend=%h empty=%b, expected 0200/0", pend_mask, wb_empty);
    end
    step();
    checks++;
    if (REG_Write !== 0 || wb_empty !== 1) begin
      errors++;
      $display("FAIL kill_pop: wr=%b empty=%b, expected 0/1", REG_Write, wb_empty);
    end
    // same-cycle push to the ALU's destination is dead on arrival
    alu_valid = 1; alu_rd = 7; alu_data = 16'h0777; expw(7, 16'h0777);
    lsu_valid = 1; lsu_rd = 7; lsu_data = 16'h7070;
    step();
    idle();
    checks++;
    if (pend_mask !== 16'h0080) begin
      errors++;
      $display("FAIL kill_same_pend: pend=%h, expected 0080", pend_mask);
    end
    step(); step();
    checks++;
    if (REG_Write !== 0 || wb_empty !== 1) begin
      errors++;
      $display("FAIL kill_same_end: wr=%b empty=%b, expected 0/1", REG_Write, wb_empty);
    end
  endtask

  task automatic test_bank_stall();
    irq_flag = 0;
    alu_valid = 1; alu_rd = 2; alu_data = 16'h0B00; expw(2, 16'h0B00);
    lsu_valid = 1; lsu_rd = 12; lsu_data = 16'hC0C0;
    step();
    alu_data = 16'h0B01; expw(2, 16'h0B01);
    lsu_rd = 3; lsu_data = 16'h0303;
    step();
    idle(); irq_flag = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (REG_Write !== 0 || pend_mask !== 16'h1008 || wb_empty !== 0) begin
        errors++;
        $display("FAIL bank_stall_%0d: wr=%b pend=%h empty=%b, expected 0/1008/0",
                 i, REG_Write, pend_mask, wb_empty);
      end
    end
    irq_flag = 0;
    expw(12, 16'hC0C0); expw(3, 16'h0303);
    step();
    checks++;
    if (REG_Write !== 1 || REG_RFD !== 12) begin
      errors++;
      $display("FAIL bank_r12: wr=%b rfd=%0d, expected 1/12", REG_Write, REG_RFD);
    end
    step();
    checks++;
    if (REG_Write !== 1 || REG_RFD !== 3) begin
      errors++;
      $display("FAIL bank_r3: wr=%b rfd=%0d, expected 1/3", REG_Write, REG_RFD);
    end
    step();
    checks++;
    if (wb_empty !== 1) begin
      errors++;
      $display("FAIL bank_end: empty=%b, expected 1", wb_empty);
    end
  endtask

  task automatic test_zero_r1();
    logic [3:0] rds [5];
    rds = '{4'd1, 4'd3, 4'd4, 4'd5, 4'd6};
    alu_valid = 1; alu_rd = 0; alu_data = 16'hFFFF;
    step();
    alu_rd = 1; alu_data = 16'hEEEE;
    step();
    idle();
    step();
    checks++;
    if (REG_Write !== 0 || pend_mask !== 0 || wb_empty !== 1) begin
      errors++;
      $display("FAIL zero_alu: wr=%b pend=%h empty=%b, expected 0/0000/1", REG_Write, pend_mask, wb_empty);
    end
    // an rd=1 load must not take a FIFO slot: four more loads are needed to fill
    for (int i = 0; i < 5; i++) begin
      alu_valid = 1; alu_rd = 2; alu_data = 16'h0D00 + 16'(i); expw(2, alu_data);
      lsu_valid = 1; lsu_rd = rds[i]; lsu_data = 16'h0E00 + 16'(rds[i]);
      checks++;
      if (lsu_ready !== 1) begin
        errors++;
        $display("FAIL r1_ready_%0d: lsu_ready=%b, expected 1", i, lsu_ready);
      end
      step();
    end
    idle();
    checks++;
    if (lsu_ready !== 0) begin
      errors++;
      $display("FAIL r1_full: lsu_ready=%b, expected 0", lsu_ready);
    end
    for (int i = 1; i < 5; i++) expw(rds[i], 16'h0E00 + 16'(rds[i]));
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (wb_empty !== 1 || REG_Write !== 0) begin
      errors++;
      $display("FAIL r1_end: empty=%b wr=%b, expected 1/0", wb_empty, REG_Write);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      lsu_valid = 1; lsu_rd = 4'(2 + i); lsu_data = 16'($urandom);
      expw(lsu_rd, lsu_data);
      checks++;
      if (lsu_ready !== 1) begin
        errors++;
        $display("FAIL b2b_ready_%0d: lsu_ready=%b, expected 1", i, lsu_ready);
      end
      step();
    end
    idle();
    step(); step();
    checks++;
    if (wb_empty !== 1 || q.size() != 0) begin
      errors++;
      $display("FAIL b2b_end: empty=%b outstanding=%0d, expected 1/0", wb_empty, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_full_drain();
    test_kill();
    test_bank_stall();
    test_zero_r1();
    test_back_to_back();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected writes never seen, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
